// File: rtl/fp_addsub_unit_if.sv
// ============================================================================
// Module   : fp_addsub_unit_if
// Purpose  : Issue/writeback handshake bundle for the FADD.S/FSUB.S unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_addsub_unit_if #(
    parameter int NEXP = 8,
    parameter int NSIG = 23,
    parameter int TAGW = 5
);
    localparam int W = NEXP + NSIG + 1;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic            in_op;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [TAGW-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_result;
    logic [TAGW-1:0] out_rd;
    logic [4:0]      out_fflags;
    logic [1:0]      busy;

    modport slave (
        input  flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_fflags, busy
    );

    modport master (
        output flush, in_valid, in_op, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_fflags, busy
    );
endinterface

`default_nettype wire

// File: rtl/fp_addsub_unit.sv
// ============================================================================
// Module   : fp_addsub_unit (+ fp_add datapath)
// Purpose  : Two-stage RV32F FADD.S/FSUB.S execute unit, round-to-nearest-even.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_add #(
    parameter int NEXP = 8,
    parameter int NSIG = 23
) (
    input  logic [NEXP+NSIG:0] i_a,
    input  logic [NEXP+NSIG:0] i_b,
    output logic [NEXP+NSIG:0] o_sum
);
    localparam int W   = NEXP + NSIG + 1;
    localparam int SW  = NSIG + 1;
    localparam int MW  = SW + 3;
    localparam int SHW = $clog2(MW + 1);
    localparam int EW  = NEXP + 1;
    localparam logic [NEXP-1:0] c_exp_max = '1;
    localparam logic [W-1:0]    c_qnan    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    logic            w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic            w_swap, w_sub, w_sticky, w_up, w_carry, w_hidden, w_sign, w_ovf;
    logic [W-1:0]    w_x, w_y;
    logic [NEXP-1:0] w_ex, w_ey, w_diff;
    logic [SHW-1:0]  w_shamt;
    logic [MW-1:0]   w_mx, w_my, w_mask, w_my_sh, w_m, w_mn;
    logic [MW:0]     w_raw;
    logic [EW-1:0]   w_e, w_lz, w_nshift, w_epre, w_efin;
    logic [SW:0]     w_rnd;

    always_comb begin
        w_a_nan = (&i_a[W-2:NSIG]) & (|i_a[NSIG-1:0]);
        w_b_nan = (&i_b[W-2:NSIG]) & (|i_b[NSIG-1:0]);
        w_a_inf = (&i_a[W-2:NSIG]) & ~(|i_a[NSIG-1:0]);
        w_b_inf = (&i_b[W-2:NSIG]) & ~(|i_b[NSIG-1:0]);

        // x always carries the larger magnitude so subtraction never borrows
        w_swap = (i_b[W-2:0] > i_a[W-2:0]);
        w_x    = w_swap ? i_b : i_a;
        w_y    = w_swap ? i_a : i_b;
        w_sub  = w_x[W-1] ^ w_y[W-1];

        w_ex = (w_x[W-2:NSIG] == '0) ? NEXP'(1) : w_x[W-2:NSIG];
        w_ey = (w_y[W-2:NSIG] == '0) ? NEXP'(1) : w_y[W-2:NSIG];
        w_mx = {|w_x[W-2:NSIG], w_x[NSIG-1:0], 3'b000};
        w_my = {|w_y[W-2:NSIG], w_y[NSIG-1:0], 3'b000};

        w_diff   = w_ex - w_ey;
        w_shamt  = (w_diff > NEXP'(MW)) ? SHW'(MW) : w_diff[SHW-1:0];
        w_mask   = ~({MW{1'b1}} << w_shamt);
        w_sticky = |(w_my & w_mask);
        w_my_sh  = (w_my >> w_shamt) | {{(MW-1){1'b0}}, w_sticky};

        w_raw = w_sub ? ({1'b0, w_mx} - {1'b0, w_my_sh})
                      : ({1'b0, w_mx} + {1'b0, w_my_sh});

        if (w_raw[MW]) begin
            w_m = {w_raw[MW:2], w_raw[1] | w_raw[0]};
            w_e = {1'b0, w_ex} + EW'(1);
        end else begin
            w_m = w_raw[MW-1:0];
            w_e = {1'b0, w_ex};
        end

        w_lz = EW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (w_m[i]) w_lz = EW'(MW - 1 - i);
        end
        // Normalisation stops at the minimum exponent, leaving a subnormal
        w_nshift = (w_lz < (w_e - EW'(1))) ? w_lz : (w_e - EW'(1));
        w_mn     = w_m << w_nshift;
        w_epre   = w_e - w_nshift;

        w_up     = w_mn[2] & (w_mn[3] | w_mn[1] | w_mn[0]);
        w_rnd    = {1'b0, w_mn[MW-1:3]} + {{SW{1'b0}}, w_up};
        w_carry  = w_rnd[SW];
        w_hidden = w_carry | w_rnd[NSIG];
        w_efin   = w_epre + {{(EW-1){1'b0}}, w_carry};
        w_ovf    = (w_efin >= {1'b0, c_exp_max});
        w_sign   = (w_sub && (w_m == '0)) ? 1'b0 : w_x[W-1];

        o_sum = {w_sign, (w_hidden ? w_efin[NEXP-1:0] : {NEXP{1'b0}}),
                 (w_carry ? {NSIG{1'b0}} : w_rnd[NSIG-1:0])};
        if (w_ovf)
            o_sum = {w_sign, c_exp_max, {NSIG{1'b0}}};

        if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (i_a[W-1] ^ i_b[W-1])))
            o_sum = c_qnan;
        else if (w_a_inf)
            o_sum = i_a;
        else if (w_b_inf)
            o_sum = i_b;
    end
endmodule

module fp_addsub_unit #(
    parameter int NEXP = 8,
    parameter int NSIG = 23,
    parameter int TAGW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_addsub_unit_if.slave bus
);
    localparam int W = NEXP + NSIG + 1;
    localparam logic [W-1:0] c_qnan = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    logic            r_s1_valid, r_s1_a_snan, r_s1_b_snan, r_s1_a_inf, r_s1_b_inf;
    logic [W-1:0]    r_s1_a, r_s1_b;
    logic [TAGW-1:0] r_s1_rd;
    logic            r_s2_valid;
    logic [W-1:0]    r_s2_result;
    logic [TAGW-1:0] r_s2_rd;
    logic [4:0]      r_s2_fflags;
    logic [1:0]      r_busy;

    logic            w_adv2, w_in_ready, w_accept, w_handshake;
    logic [W-1:0]    w_b_eff, w_sum, w_result;
    logic            w_a_snan, w_b_snan, w_a_inf, w_b_inf;
    logic            w_sum_nan, w_sum_inf, w_nv, w_of;
    logic [4:0]      w_fflags;

    assign w_adv2      = ~r_s2_valid | bus.out_ready;
    assign w_in_ready  = ~r_s1_valid | w_adv2;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_handshake = r_s2_valid & bus.out_ready;

    // FSUB is an FADD with rs2's sign inverted
    assign w_b_eff  = {bus.in_b[W-1] ^ bus.in_op, bus.in_b[W-2:0]};
    assign w_a_snan = (&bus.in_a[W-2:NSIG]) & (|bus.in_a[NSIG-1:0]) & ~bus.in_a[NSIG-1];
    assign w_b_snan = (&w_b_eff[W-2:NSIG]) & (|w_b_eff[NSIG-1:0]) & ~w_b_eff[NSIG-1];
    assign w_a_inf  = (&bus.in_a[W-2:NSIG]) & ~(|bus.in_a[NSIG-1:0]);
    assign w_b_inf  = (&w_b_eff[W-2:NSIG]) & ~(|w_b_eff[NSIG-1:0]);

    fp_add #(.NEXP(NEXP), .NSIG(NSIG)) u_fp_add (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_sum (w_sum)
    );

    assign w_sum_nan = (&w_sum[W-2:NSIG]) & (|w_sum[NSIG-1:0]);
    assign w_sum_inf = (&w_sum[W-2:NSIG]) & ~(|w_sum[NSIG-1:0]);
    assign w_nv      = r_s1_a_snan | r_s1_b_snan
                     | (r_s1_a_inf & r_s1_b_inf & (r_s1_a[W-1] ^ r_s1_b[W-1]));
    assign w_of      = w_sum_inf & ~r_s1_a_inf & ~r_s1_b_inf;
    assign w_fflags  = {w_nv, 1'b0, w_of, 1'b0, w_of};
    assign w_result  = w_sum_nan ? c_qnan : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_rd     <= '0;
            r_s1_a_snan <= 1'b0;
            r_s1_b_snan <= 1'b0;
            r_s1_a_inf  <= 1'b0;
            r_s1_b_inf  <= 1'b0;
        end else if (bus.flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_a      <= bus.in_a;
                r_s1_b      <= w_b_eff;
                r_s1_rd     <= bus.in_rd;
                r_s1_a_snan <= w_a_snan;
                r_s1_b_snan <= w_b_snan;
                r_s1_a_inf  <= w_a_inf;
                r_s1_b_inf  <= w_b_inf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_rd     <= '0;
            r_s2_fflags <= '0;
        end else if (bus.flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= w_result;
                r_s2_rd     <= r_s1_rd;
                r_s2_fflags <= w_fflags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= 2'd0;
        else if (bus.flush)
            r_busy <= 2'd0;
        else if (w_accept & ~w_handshake)
            r_busy <= r_busy + 2'd1;
        else if (~w_accept & w_handshake)
            r_busy <= r_busy - 2'd1;
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.out_result = r_s2_result;
    assign bus.out_rd     = r_s2_rd;
    assign bus.out_fflags = r_s2_fflags;
    assign bus.busy       = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_unit.sv
// ============================================================================
// Module   : tb_fp_addsub_unit
// Purpose  : Scoreboard bench for fp_addsub_unit against an exact-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_addsub_unit;
    logic clk;
    logic rst_n;
    logic rand_rdy;
    int   n_checks;
    int   n_pass;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        logic [4:0]  rd;
    } exp_t;
    exp_t sb[$];

    fp_addsub_unit_if #(.NEXP(8), .NSIG(23), .TAGW(5)) bus ();

    fp_addsub_unit #(.NEXP(8), .NSIG(23), .TAGW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Exact value: sum both operands as integers on a common 2^emin grid, then round once
    function automatic logic [31:0] ref_add(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bb;
        logic a_nan, b_nan, a_inf, b_inf, sgn;
        int ea, eb, emin, p, k, e2;
        logic signed [319:0] va, vb, s;
        logic [319:0] mag, r, rem, half;
        bb    = {b[31] ^ op, b[30:0]};
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if (a_inf && b_inf) return (a[31] != bb[31]) ? 32'h7FC00000 : a;
        if (a_inf) return a;
        if (b_inf) return bb;
        ea   = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb   = (bb[30:23] == 0) ? 1 : int'(bb[30:23]);
        emin = (ea < eb) ? ea : eb;
        va = 320'({a[30:23] != 0, a[22:0]}) << (ea - emin);
        vb = 320'({bb[30:23] != 0, bb[22:0]}) << (eb - emin);
        if (a[31]) va = -va;
        if (bb[31]) vb = -vb;
        s = va + vb;
        if (s == 0) return {a[31] & bb[31], 31'd0};
        sgn = (s < 0);
        mag = sgn ? $unsigned(-s) : $unsigned(s);
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        k   = (p > 23) ? p - 23 : 0;
        r   = mag >> k;
        rem = mag - (r << k);
        if (k > 0) begin
            half = 320'd1 << (k - 1);
            if ((rem > half) || ((rem == half) && r[0])) r = r + 1;
        end
        e2 = k + emin - 150;
        if (r[24]) begin r = r >> 1; e2++; end
        while (!r[23] && (e2 > -149)) begin r = r << 1; e2--; end
        if (!r[23]) return {sgn, 8'h00, r[22:0]};
        if (e2 + 150 >= 255) return {sgn, 8'hFF, 23'd0};
        return {sgn, 8'(e2 + 150), r[22:0]};
    endfunction

    function automatic logic [4:0] ref_flags(input logic op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] res);
        logic [31:0] bb;
        logic a_snan, b_snan, a_inf, b_inf, nv, of;
        bb     = {b[31] ^ op, b[30:0]};
        a_snan = (a[30:23] == 8'hFF) && (a[22:0] != 0) && !a[22];
        b_snan = (bb[30:23] == 8'hFF) && (bb[22:0] != 0) && !bb[22];
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf  = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
        nv = a_snan || b_snan || (a_inf && b_inf && (a[31] != bb[31]));
        of = (res[30:0] == 31'h7F800000) && !a_inf && !b_inf;
        return {nv, 1'b0, of, 1'b0, of};
    endfunction

    // Push the expected response whenever the DUT takes an operation
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && !bus.flush && bus.in_valid && bus.in_ready) begin
            e.res   = ref_add(bus.in_op, bus.in_a, bus.in_b);
            e.flags = ref_flags(bus.in_op, bus.in_a, bus.in_b, e.res);
            e.rd    = bus.in_rd;
            sb.push_back(e);
        end
    end

    // Pop and compare on every output handshake; kills discard what is in flight
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("sb_result", 64'(bus.out_result), 64'(e.res));
                check("sb_fflags", 64'(bus.out_fflags), 64'(e.flags));
                check("sb_rd", 64'(bus.out_rd), 64'(e.rd));
            end
        end
        if (bus.flush || !rst_n) sb.delete();
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Offer one op and hold it until accepted; returns 1 ns after the accepting edge
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        logic got;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            got = bus.in_ready;
            @(posedge clk);
            #1;
            if (got) return;
        end
        check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic directed(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                            input logic [31:0] eres, input logic [4:0] efl);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_rd     = rd;
        @(negedge clk);
        check("dir_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("dir_early_valid", 64'(bus.out_valid), 64'(0));
        @(posedge clk);
        #1;
        check("dir_out_valid", 64'(bus.out_valid), 64'(1));
        check("dir_result", 64'(bus.out_result), 64'(eres));
        check("dir_fflags", 64'(bus.out_fflags), 64'(efl));
        check("dir_rd", 64'(bus.out_rd), 64'(rd));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 7))
            0: x[30:23] = 8'($urandom_range(120, 134));
            1: x[30:23] = 8'h00;
            2: x[30:23] = 8'($urandom_range(250, 254));
            3: begin
                case ($urandom_range(0, 7))
                    0: x = 32'h00000000;
                    1: x = 32'h80000000;
                    2: x = 32'h7F800000;
                    3: x = 32'hFF800000;
                    4: x = 32'h7FC00000;
                    5: x = 32'h7F800001;
                    6: x = 32'h00000001;
                    default: x = 32'h7F7FFFFF;
                endcase
            end
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        logic [31:0] ra, rb;
        n_checks      = 0;
        n_pass        = 0;
        rand_rdy      = 1'b0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_result", 64'(bus.out_result), 64'(0));
        check("rst_out_rd", 64'(bus.out_rd), 64'(0));
        check("rst_out_fflags", 64'(bus.out_fflags), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

        directed(1'b0, 32'h3F800000, 32'h40000000, 5'd3,  32'h40400000, 5'b00000);
        directed(1'b1, 32'h3F800000, 32'h3F800000, 5'd4,  32'h00000000, 5'b00000);
        directed(1'b1, 32'h40400000, 32'h3F800000, 5'd5,  32'h40000000, 5'b00000);
        directed(1'b0, 32'h7F800000, 32'hFF800000, 5'd6,  32'h7FC00000, 5'b10000);
        directed(1'b1, 32'h7F800000, 32'h7F800000, 5'd7,  32'h7FC00000, 5'b10000);
        directed(1'b0, 32'h7F800001, 32'h3F800000, 5'd8,  32'h7FC00000, 5'b10000);
        directed(1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd9,  32'h7F800000, 5'b00101);
        drain();

        // Backpressure: two ops fill the pipe, the third waits
        bus.out_ready = 1'b0;
        send(1'b0, 32'h3F800000, 32'h40000000, 5'd10);
        send(1'b1, 32'h40A00000, 32'h3FC00000, 5'd11);
        bus.in_op = 1'b0; bus.in_a = 32'hC1200000; bus.in_b = 32'h3E800000; bus.in_rd = 5'd12;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'(0));
            check("stall_busy", 64'(bus.busy), 64'(2));
            check("stall_out_valid", 64'(bus.out_valid), 64'(1));
            check("stall_result", 64'(bus.out_result), 64'(32'h40400000));
            check("stall_rd", 64'(bus.out_rd), 64'(10));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(1'b0, 32'hC1200000, 32'h3E800000, 5'd12);
        send(1'b1, 32'h00000001, 32'h80000001, 5'd13);
        bus.in_valid = 1'b0;
        drain();

        // Flush with two ops in flight and a same-cycle offer
        bus.out_ready = 1'b0;
        send(1'b0, 32'h3F800000, 32'h3F800000, 5'd14);
        send(1'b0, 32'h40000000, 32'h40000000, 5'd15);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 32'h41000000; bus.in_b = 32'h41000000; bus.in_rd = 5'd16;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_busy", 64'(bus.busy), 64'(0));
        check("flush_in_ready", 64'(bus.in_ready), 64'(1));
        directed(1'b0, 32'h40400000, 32'h40400000, 5'd17, 32'h40C00000, 5'b00000);
        drain();

        // Asynchronous reset mid-stall
        bus.out_ready = 1'b0;
        send(1'b0, 32'h3F800000, 32'h40000000, 5'd18);
        send(1'b1, 32'h3F800000, 32'h40000000, 5'd19);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'(0));
        check("arst_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_stale", 64'(bus.out_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        directed(1'b1, 32'h40000000, 32'h3F800000, 5'd20, 32'h3F800000, 5'b00000);
        drain();

        // Randomized stream with random writeback backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            ra = rand_fp();
            rb = ($urandom_range(0, 2) == 0) ? (ra ^ (32'($urandom) & 32'h800000FF)) : rand_fp();
            send(1'($urandom_range(0, 1)), ra, rb, 5'($urandom_range(0, 31)));
        end
        bus.in_valid = 1'b0;
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        check("end_busy", 64'(bus.busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fp_addsub_unit.md
Name: fp_addsub_unit

Overview:
- Pipelined RV32F execute unit for FADD.S and FSUB.S; sits between the FP issue/operand-read stage and FP writeback.
- Registers the operands and applies the FSUB sign flip to operand b.
- Drives the existing combinational fp_add datapath, registers its result, canonicalises NaNs, derives fflags, and presents the result with a destination tag over a valid/ready handshake.

Parameters:
- NEXP, 8, exponent width
- NSIG, 23, stored significand width; word width W = NEXP+NSIG+1
- TAGW, 5, destination register tag width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline kill
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  1  0 = FADD.S, 1 = FSUB.S
- in_a  in  W  operand rs1
- in_b  in  W  operand rs2
- in_rd  in  TAGW  destination tag
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  W  rounded/packed result
- out_rd  out  TAGW  tag of result
- out_fflags  out  5  {NV,DZ,OF,UF,NX}
- busy  out  2  operations in flight (0..2)

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid = 0, s2_valid = 0, out_valid = 0, out_result = 0, out_rd = 0, out_fflags = 0, busy = 0. in_ready = 1 on the first cycle after release.
- Stage S1 register:
  - Holds a, b' = {b[W-1]^in_op, b[W-2:0]}, tag, and pre-flags.
  - Pre-flags: a_snan, b_snan, a_inf, b_inf.
- Datapath: one fp_add instance, combinational from S1 to S2.
- Stage S2 register holds the output fields. S2 is the output register; there is no further buffering.
- Advance rule:
  - adv2 = !s2_valid | out_ready.
  - in_ready = !s1_valid | adv2.
  - Accept = in_valid & in_ready.
- Latency and throughput:
  - Op accepted at edge N appears with out_valid = 1 after edge N+1 (2 cycles).
  - Throughput is 1 op/cycle with no backpressure.
- Stall: while out_valid & !out_ready, S2 and its outputs hold stable and S1 holds. Order is strictly preserved.
- NaN result:
  - Applies when exponent is all ones and significand is nonzero.
  - out_result = 0x7FC00000, i.e. {0, all-ones exponent, 1, zeros}.
- fflags:
  - NV = a_snan | b_snan | (a_inf & b_inf & (a sign != b' sign)).
  - OF = result is ±infinity & !a_inf & !b_inf.
  - NX = OF.
  - DZ = 0, UF = 0.
- busy:
  - +1 on accept, −1 on output handshake (out_valid & out_ready).
  - Simultaneous accept and handshake leaves busy unchanged.
  - Never exceeds 2.
- flush (synchronous, highest priority below reset):
  - Next edge sets s1_valid = 0, s2_valid = 0, busy = 0.
  - A same-cycle in_valid is dropped.
  - A same-cycle output handshake still counts as delivered for the consumer.
- Reset mid-operation: all in-flight ops are discarded immediately and no stale out_valid appears after release.
- out_result, out_rd and out_fflags are don't-care when out_valid = 0, but hold their last values; they only load when S2 advances with s1_valid = 1.

Test Plan:
- FADD 0x3F800000 + 0x40000000, out_ready = 1 -> two cycles later out_valid = 1, out_result = 0x40400000, fflags = 00000, out_rd echoed.
- FSUB 0x3F800000 − 0x3F800000 -> out_result = 0x00000000, fflags = 00000. FSUB 0x40400000 − 0x3F800000 -> 0x40000000.
- FADD 0x7F800000 + 0xFF800000 -> 0x7FC00000, fflags = 10000. FSUB 0x7F800000 − 0x7F800000 -> 0x7FC00000, NV = 1.
- FADD 0x7F800001 (sNaN) + 0x3F800000 -> 0x7FC00000, fflags = 10000. FADD 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, fflags = 00101.
- Issue 4 back-to-back ops with out_ready = 0 for 4 cycles:
  - in_ready drops after 2 accepts and busy = 2.
  - Outputs hold stable while out_ready = 0.
  - After out_ready = 1, all 4 results emerge in order with correct tags and none are lost or duplicated.
- With 2 ops in flight, assert flush (and separately deassert rst_n mid-stall):
  - out_valid = 0 and busy = 0 next cycle (immediately for reset).
  - A following op completes normally with 2-cycle latency.
